led_frame_tx: RTL



---
 rtl/led_string_pkg.sv | 24 ++
 rtl/ledtx_sck_gen.sv | 36 +++
 rtl/led_frame_tx.sv | 79 +++++++
 3 files changed

// File: rtl/led_string_pkg.sv
// led_string_pkg: frame codes, constants and frame builder shared by the LED string sequencer and transmitter.
package led_string_pkg;
    localparam int FRAME_BITS = 32;
    localparam logic [1:0] INPUT_TYPE_START = 2'd0;
    localparam logic [1:0] INPUT_TYPE_LED   = 2'd1;
    localparam logic [1:0] INPUT_TYPE_END   = 2'd2;
    localparam logic [2:0] LED_FRAME_HDR = 3'b111;
    localparam logic [FRAME_BITS-1:0] START_FRAME = 32'h0000_0000;
    localparam logic [FRAME_BITS-1:0] END_FRAME   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} tx_state_t;

    // Type code 3 is not defined upstream and is sent as an end frame.
    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [1:0] t,
        input logic [4:0] br,
        input logic [7:0] b,
        input logic [7:0] g,
        input logic [7:0] r
    );
        return t == INPUT_TYPE_START ? START_FRAME :
               t == INPUT_TYPE_LED   ? {LED_FRAME_HDR, br, b, g, r} : END_FRAME;
    endfunction
endpackage

// File: rtl/ledtx_sck_gen.sv
// ledtx_sck_gen: divides clk into sck while enabled and flags the edge about to be produced.
module ledtx_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);
    localparam int W = $clog2(CLK_DIV) + 1;
    localparam logic [W-1:0] DIV_MAX = W'(CLK_DIV - 1);

    logic [W-1:0] r_div_cnt;
    logic         r_sck;
    logic         w_tick;

    assign w_tick = i_en && r_div_cnt == DIV_MAX;
    assign o_rise = w_tick && !r_sck;
    assign o_fall = w_tick && r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_sck     <= w_tick ? ~r_sck : r_sck;
        end
    end
endmodule

// File: rtl/led_frame_tx.sv
// led_frame_tx: latches one 32-bit LED string frame on a start edge and shifts it out MSB-first on mosi/sck.
module led_frame_tx
    import led_string_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter logic [4:0] BRIGHTNESS = 5'd31
) (
    input  logic       ledtx_clk,
    input  logic       ledtx_reset_n,
    input  logic [7:0] blue_input,
    input  logic [7:0] green_input,
    input  logic [7:0] red_input,
    input  logic [1:0] type_input,
    input  logic       ledtx_start,
    output logic       ledtx_busy,
    output logic       mosi,
    output logic       sck
);
    tx_state_t             r_state, w_state_nxt;
    logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt, w_frame;
    logic [4:0]            r_bit_cnt, w_bit_nxt;
    logic                  r_start_q, r_mosi, w_mosi_nxt, r_busy;
    logic                  w_rise, w_fall;

    ledtx_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .i_clk  (ledtx_clk),
        .i_rst_n(ledtx_reset_n),
        .i_en   (r_busy),
        .o_sck  (sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_frame    = make_frame(type_input, BRIGHTNESS, blue_input, green_input, red_input);
    assign ledtx_busy = r_busy;
    assign mosi       = r_mosi;

    always_ff @(posedge ledtx_clk or negedge ledtx_reset_n) begin
        if (!ledtx_reset_n) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_start_q <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_start_q <= ledtx_start;
            r_mosi    <= w_mosi_nxt;
            r_busy    <= w_state_nxt != IDLE;
        end
    end

    // mosi only moves at launch and on sck falling edges, keeping it centred on each rise.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_bit_nxt   = r_bit_cnt;
        w_mosi_nxt  = r_mosi;
        case (r_state)
            IDLE: if (ledtx_start && !r_start_q) begin
                w_state_nxt = LOW;
                w_shreg_nxt = w_frame;
                w_bit_nxt   = '0;
                w_mosi_nxt  = w_frame[FRAME_BITS-1];
            end
            LOW: if (w_rise) w_state_nxt = HIGH;
            HIGH: if (w_fall) begin
                w_shreg_nxt = r_shreg << 1;
                w_bit_nxt   = r_bit_cnt + 1'b1;
                w_state_nxt = r_bit_cnt == 5'd31 ? IDLE : LOW;
                w_mosi_nxt  = r_bit_cnt == 5'd31 ? 1'b0 : r_shreg[FRAME_BITS-2];
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule
